// File: rtl/sweep_sequencer.sv
// sweep_sequencer: ping scheduler stepping the beam angle through settle, burst, listen and report phases.
module sweep_sequencer #(
   parameter int SETTLE_CYCLES = 16,
   parameter int BURST_CYCLES  = 524288,
   parameter int LISTEN_CYCLES = 16252928,
   parameter int ANGLE_WIDTH   = 8,
   parameter int ANGLE_MIN     = -30,
   parameter int ANGLE_MAX     = 30,
   parameter int ANGLE_STEP    = 10,
   parameter int RANGE_WIDTH   = 16
) (
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic                          enable_in,
   input  logic                          sweep_mode_in,
   input  logic signed [ANGLE_WIDTH-1:0] hold_angle_in,
   input  logic                          echo_valid_in,
   input  logic        [RANGE_WIDTH-1:0] range_in,
   output logic signed [ANGLE_WIDTH-1:0] beam_angle_out,
   output logic                          datapath_rst_out,
   output logic                          tx_enable_out,
   output logic                          rx_enable_out,
   output logic                          result_valid_out,
   output logic signed [ANGLE_WIDTH-1:0] result_angle_out,
   output logic        [RANGE_WIDTH-1:0] result_range_out,
   output logic                          result_hit_out,
   output logic                          sweep_done_out,
   output logic                 [2:0]    state_out
);
   localparam int MAX_SB = (SETTLE_CYCLES > BURST_CYCLES) ? SETTLE_CYCLES : BURST_CYCLES;
   localparam int MAXC   = (MAX_SB > LISTEN_CYCLES) ? MAX_SB : LISTEN_CYCLES;
   localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] C_SETTLE = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] C_BURST  = CW'(BURST_CYCLES - 1);
   localparam logic [CW-1:0] C_LISTEN = CW'(LISTEN_CYCLES - 1);
   localparam logic signed [ANGLE_WIDTH-1:0] A_MIN  = ANGLE_WIDTH'(ANGLE_MIN);
   localparam logic signed [ANGLE_WIDTH-1:0] A_MAX  = ANGLE_WIDTH'(ANGLE_MAX);
   localparam logic signed [ANGLE_WIDTH-1:0] A_STEP = ANGLE_WIDTH'(ANGLE_STEP);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETTLE = 3'd1,
      BURST  = 3'd2,
      LISTEN = 3'd3,
      REPORT = 3'd4
   } state_t;

   state_t                        state_q, state_d;
   logic [CW-1:0]                 cnt_q, cnt_d;
   logic signed [ANGLE_WIDTH-1:0] angle_q, angle_d;
   logic                          sweep_q, sweep_d;
   logic                          hit_q, hit_d;
   logic [RANGE_WIDTH-1:0]        range_q, range_d;
   logic                          dp_rst_q, dp_rst_d;
   logic                          tx_q, tx_d;
   logic                          rx_q, rx_d;
   logic                          valid_q, valid_d;
   logic                          done_q, done_d;
   logic signed [ANGLE_WIDTH-1:0] res_angle_q, res_angle_d;
   logic [RANGE_WIDTH-1:0]        res_range_q, res_range_d;
   logic                          res_hit_q, res_hit_d;

   // Phase sequencing, angle stepping, first-echo capture and result formation.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      angle_d     = angle_q;
      sweep_d     = sweep_q;
      hit_d       = hit_q;
      range_d     = range_q;
      valid_d     = 1'b0;
      done_d      = 1'b0;
      res_angle_d = res_angle_q;
      res_range_d = res_range_q;
      res_hit_d   = res_hit_q;
      case (state_q)
         IDLE: if (enable_in) begin
            state_d = SETTLE;
            cnt_d   = C_SETTLE;
            angle_d = sweep_mode_in ? A_MIN : hold_angle_in;
            sweep_d = sweep_mode_in;
            hit_d   = 1'b0;
            range_d = '0;
         end
         SETTLE: if (cnt_q == '0) begin
            state_d = BURST;
            cnt_d   = C_BURST;
         end else cnt_d = cnt_q - 1'b1;
         BURST: if (cnt_q == '0) begin
            state_d = LISTEN;
            cnt_d   = C_LISTEN;
         end else cnt_d = cnt_q - 1'b1;
         LISTEN: begin
            if (echo_valid_in && !hit_q) begin
               hit_d   = 1'b1;
               range_d = range_in;
            end
            if (cnt_q == '0) begin
               state_d     = REPORT;
               valid_d     = 1'b1;
               res_angle_d = angle_q;
               res_hit_d   = hit_d;
               res_range_d = hit_d ? range_d : '1;
               done_d      = sweep_q && (angle_q == A_MAX);
            end else cnt_d = cnt_q - 1'b1;
         end
         REPORT: if (!enable_in) state_d = IDLE;
         else begin
            state_d = SETTLE;
            cnt_d   = C_SETTLE;
            hit_d   = 1'b0;
            range_d = '0;
            sweep_d = sweep_mode_in;
            angle_d = !sweep_mode_in ? hold_angle_in :
                      (sweep_q && angle_q != A_MAX) ? angle_q + A_STEP : A_MIN;
         end
         default: state_d = IDLE;
      endcase
      dp_rst_d = (state_d == IDLE) || (state_d == SETTLE);
      tx_d     = state_d == BURST;
      rx_d     = state_d == LISTEN;
   end

   // State and registered outputs; reset clears everything asynchronously.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         angle_q     <= '0;
         sweep_q     <= 1'b0;
         hit_q       <= 1'b0;
         range_q     <= '0;
         dp_rst_q    <= 1'b1;
         tx_q        <= 1'b0;
         rx_q        <= 1'b0;
         valid_q     <= 1'b0;
         done_q      <= 1'b0;
         res_angle_q <= '0;
         res_range_q <= '0;
         res_hit_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         angle_q     <= angle_d;
         sweep_q     <= sweep_d;
         hit_q       <= hit_d;
         range_q     <= range_d;
         dp_rst_q    <= dp_rst_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         valid_q     <= valid_d;
         done_q      <= done_d;
         res_angle_q <= res_angle_d;
         res_range_q <= res_range_d;
         res_hit_q   <= res_hit_d;
      end
   end

   assign beam_angle_out   = angle_q;
   assign datapath_rst_out = dp_rst_q;
   assign tx_enable_out    = tx_q;
   assign rx_enable_out    = rx_q;
   assign result_valid_out = valid_q;
   assign result_angle_out = res_angle_q;
   assign result_range_out = res_range_q;
   assign result_hit_out   = res_hit_q;
   assign sweep_done_out   = done_q;
   assign state_out        = state_q;
endmodule

// File: tb/tb_sweep_sequencer.sv
// tb_sweep_sequencer: table-driven ping checks plus enable-drop and mid-ping reset sequences.
module tb_sweep_sequencer;
   logic              clk_in = 1'b0;
   logic              rst_in = 1'b1;
   logic              enable_in = 1'b0;
   logic              sweep_mode_in = 1'b0;
   logic signed [7:0] hold_angle_in = '0;
   logic              echo_valid_in = 1'b0;
   logic [15:0]       range_in = '0;
   logic signed [7:0] beam_angle_out;
   logic              datapath_rst_out;
   logic              tx_enable_out;
   logic              rx_enable_out;
   logic              result_valid_out;
   logic signed [7:0] result_angle_out;
   logic [15:0]       result_range_out;
   logic              result_hit_out;
   logic              sweep_done_out;
   logic [2:0]        state_out;
   int                n_cmp = 0;
   int                n_bad = 0;

   sweep_sequencer #(
      .SETTLE_CYCLES(2),
      .BURST_CYCLES(4),
      .LISTEN_CYCLES(10)
   ) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .enable_in(enable_in),
      .sweep_mode_in(sweep_mode_in),
      .hold_angle_in(hold_angle_in),
      .echo_valid_in(echo_valid_in),
      .range_in(range_in),
      .beam_angle_out(beam_angle_out),
      .datapath_rst_out(datapath_rst_out),
      .tx_enable_out(tx_enable_out),
      .rx_enable_out(rx_enable_out),
      .result_valid_out(result_valid_out),
      .result_angle_out(result_angle_out),
      .result_range_out(result_range_out),
      .result_hit_out(result_hit_out),
      .sweep_done_out(sweep_done_out),
      .state_out(state_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic              en;
      logic              sweep;
      logic signed [7:0] hold;
      int                e1;
      logic [15:0]       r1;
      int                e2;
      logic [15:0]       r2;
      logic signed [7:0] ang;
      logic [15:0]       rng;
      logic              hit;
      logic              done;
   } vec_t;

   vec_t tbl [17];

   function automatic vec_t mk(input logic en, input logic sweep, input logic signed [7:0] hold,
                               input int e1, input logic [15:0] r1, input int e2, input logic [15:0] r2,
                               input logic signed [7:0] ang, input logic [15:0] rng, input logic hit,
                               input logic done);
      vec_t v;
      v.en = en; v.sweep = sweep; v.hold = hold; v.e1 = e1; v.r1 = r1; v.e2 = e2; v.r2 = r2;
      v.ang = ang; v.rng = rng; v.hit = hit; v.done = done;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
      end
   endtask

   // Runs one ping from the negedge of its first SETTLE cycle through its REPORT cycle.
   task automatic run_ping(input vec_t v);
      sweep_mode_in = v.sweep;
      hold_angle_in = v.hold;
      for (int o = 0; o < 17; o++) begin
         if (o == 3) enable_in = v.en;
         echo_valid_in = (o == v.e1) || (o == v.e2);
         range_in = (o == v.e1) ? v.r1 : (o == v.e2) ? v.r2 : 16'hBEEF;
         chk("state", 32'(state_out), (o < 2) ? 1 : (o < 6) ? 2 : (o < 16) ? 3 : 4);
         chk("ctrl", 32'({datapath_rst_out, tx_enable_out, rx_enable_out, result_valid_out, sweep_done_out}),
             32'({o < 2, o >= 2 && o < 6, o >= 6 && o < 16, o == 16, o == 16 && v.done}));
         chk("beam", 32'(beam_angle_out), 32'(v.ang));
         if (o == 16) begin
            chk("res_angle", 32'(result_angle_out), 32'(v.ang));
            chk("res_range", 32'(result_range_out), 32'(v.rng));
            chk("res_hit", 32'(result_hit_out), 32'(v.hit));
         end
         @(posedge clk_in);
         @(negedge clk_in);
      end
      echo_valid_in = 1'b0;
   endtask

   // Datapath gating invariant checked every cycle.
   always @(negedge clk_in) begin
      n_cmp++;
      if ((tx_enable_out && rx_enable_out) || (datapath_rst_out && (tx_enable_out || rx_enable_out))) begin
         n_bad++;
         $display("FAIL gating at %0t: tx=%0b rx=%0b dp_rst=%0b", $time, tx_enable_out, rx_enable_out,
                  datapath_rst_out);
      end
   end

   initial begin
      tbl[0]  = mk(1'b1, 1'b1, 8'sd0, -1, 16'h0, -1, 16'h0, -8'sd30, 16'hFFFF, 1'b0, 1'b0);
      tbl[1]  = mk(1'b1, 1'b1, 8'sd0, -1, 16'h0, -1, 16'h0, -8'sd20, 16'hFFFF, 1'b0, 1'b0);
      tbl[2]  = mk(1'b1, 1'b1, 8'sd0, -1, 16'h0, -1, 16'h0, -8'sd10, 16'hFFFF, 1'b0, 1'b0);
      tbl[3]  = mk(1'b1, 1'b1, 8'sd0, -1, 16'h0, -1, 16'h0, 8'sd0, 16'hFFFF, 1'b0, 1'b0);
      tbl[4]  = mk(1'b1, 1'b1, 8'sd0, -1, 16'h0, -1, 16'h0, 8'sd10, 16'hFFFF, 1'b0, 1'b0);
      tbl[5]  = mk(1'b1, 1'b1, 8'sd0, -1, 16'h0, -1, 16'h0, 8'sd20, 16'hFFFF, 1'b0, 1'b0);
      tbl[6]  = mk(1'b1, 1'b1, 8'sd0, -1, 16'h0, -1, 16'h0, 8'sd30, 16'hFFFF, 1'b0, 1'b1);
      tbl[7]  = mk(1'b1, 1'b1, 8'sd0, 8, 16'h0123, 12, 16'h0456, -8'sd30, 16'h0123, 1'b1, 1'b0);
      tbl[8]  = mk(1'b1, 1'b1, 8'sd0, 3, 16'h0777, -1, 16'h0, -8'sd20, 16'hFFFF, 1'b0, 1'b0);
      tbl[9]  = mk(1'b1, 1'b0, -8'sd20, 15, 16'h0042, -1, 16'h0, -8'sd10, 16'h0042, 1'b1, 1'b0);
      tbl[10] = mk(1'b1, 1'b0, -8'sd20, -1, 16'h0, -1, 16'h0, -8'sd20, 16'hFFFF, 1'b0, 1'b0);
      tbl[11] = mk(1'b1, 1'b1, -8'sd20, -1, 16'h0, -1, 16'h0, -8'sd20, 16'hFFFF, 1'b0, 1'b0);
      tbl[12] = mk(1'b1, 1'b0, 8'sd30, -1, 16'h0, -1, 16'h0, -8'sd30, 16'hFFFF, 1'b0, 1'b0);
      tbl[13] = mk(1'b1, 1'b1, 8'sd30, -1, 16'h0, -1, 16'h0, 8'sd30, 16'hFFFF, 1'b0, 1'b0);
      tbl[14] = mk(1'b0, 1'b1, 8'sd0, -1, 16'h0, -1, 16'h0, -8'sd30, 16'hFFFF, 1'b0, 1'b0);
      tbl[15] = mk(1'b1, 1'b1, 8'sd0, -1, 16'h0, -1, 16'h0, -8'sd30, 16'hFFFF, 1'b0, 1'b0);
      tbl[16] = mk(1'b1, 1'b1, 8'sd0, 9, 16'h0099, -1, 16'h0, -8'sd30, 16'h0099, 1'b1, 1'b0);
      repeat (3) @(negedge clk_in);
      chk("rst_state", 32'(state_out), 0);
      chk("rst_ctrl", 32'({datapath_rst_out, tx_enable_out, rx_enable_out, result_valid_out, sweep_done_out}), 32'h10);
      chk("rst_beam", 32'(beam_angle_out), 0);
      chk("rst_res", 32'({result_angle_out, result_range_out, result_hit_out}), 0);
      rst_in = 1'b0;
      repeat (2) @(negedge clk_in);
      chk("idle_state", 32'(state_out), 0);
      chk("idle_dp_rst", 32'(datapath_rst_out), 1);
      enable_in = 1'b1;
      sweep_mode_in = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      for (int i = 0; i < 15; i++) run_ping(tbl[i]);
      for (int i = 0; i < 5; i++) begin
         chk("drop_state", 32'(state_out), 0);
         chk("drop_ctrl", 32'({datapath_rst_out, tx_enable_out, rx_enable_out, result_valid_out}), 32'h8);
         chk("drop_beam", 32'(beam_angle_out), 32'(-8'sd30));
         chk("drop_hold_range", 32'(result_range_out), 32'hFFFF);
         @(posedge clk_in);
         @(negedge clk_in);
      end
      enable_in = 1'b1;
      sweep_mode_in = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      run_ping(tbl[15]);
      for (int i = 0; i < 9; i++) begin
         @(posedge clk_in);
         @(negedge clk_in);
      end
      chk("pre_rst_state", 32'(state_out), 3);
      chk("pre_rst_beam", 32'(beam_angle_out), 32'(-8'sd20));
      rst_in = 1'b1;
      #1;
      chk("async_state", 32'(state_out), 0);
      chk("async_ctrl", 32'({datapath_rst_out, tx_enable_out, rx_enable_out, result_valid_out, sweep_done_out}), 32'h10);
      chk("async_beam", 32'(beam_angle_out), 0);
      chk("async_res", 32'({result_angle_out, result_range_out, result_hit_out}), 0);
      @(negedge clk_in);
      chk("held_state", 32'(state_out), 0);
      chk("held_valid", 32'(result_valid_out), 0);
      rst_in = 1'b0;
      @(posedge clk_in);
      @(negedge clk_in);
      run_ping(tbl[16]);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/sweep_sequencer.md
# sweep_sequencer

Ping-cycle scheduler for the sonar front end. Steps the shared beam angle across a sweep, holds the transmit/receive datapath in reset while the angle settles, gates the transmit burst, and opens the listen window. It then collects the first echo range per angle and reports one result per ping. It sits between the control switches and the transmit beamformer, SPI ADC controllers, receive beamformer and time-of-flight datapath.

## Interface
Parameters:
- SETTLE_CYCLES, 16: cycles the datapath is held in reset after each angle update.
- BURST_CYCLES, 524288: transmit burst length in cycles.
- LISTEN_CYCLES, 16252928: listen window length in cycles.
- ANGLE_WIDTH, 8: signed angle width in degrees.
- ANGLE_MIN, -30: first sweep angle.
- ANGLE_MAX, 30: last sweep angle.
- ANGLE_STEP, 10: sweep increment; (ANGLE_MAX-ANGLE_MIN) is a multiple of ANGLE_STEP.
- RANGE_WIDTH, 16: range word width.

Ports:
- clk_in, in, 1: 100 MHz system clock.
- rst_in, in, 1: asynchronous, active-high reset.
- enable_in, in, 1: run pings while high.
- sweep_mode_in, in, 1: 1 = sweep ANGLE_MIN..ANGLE_MAX; 0 = hold at hold_angle_in.
- hold_angle_in, in, ANGLE_WIDTH signed: angle used in hold mode.
- echo_valid_in, in, 1: range_in valid, single-cycle pulse from time-of-flight.
- range_in, in, RANGE_WIDTH: measured range.
- beam_angle_out, out, ANGLE_WIDTH signed: angle applied to sin lookup and beamformers.
- datapath_rst_out, out, 1: reset to transmit/receive datapath.
- tx_enable_out, out, 1: gates the transducer drive.
- rx_enable_out, out, 1: enables SPI sampling and echo detection.
- result_valid_out, out, 1: one-cycle result strobe.
- result_angle_out, out, ANGLE_WIDTH signed: angle of the reported ping.
- result_range_out, out, RANGE_WIDTH: captured range; all ones on a miss.
- result_hit_out, out, 1: echo captured this ping.
- sweep_done_out, out, 1: pulses with the result of the ANGLE_MAX ping in sweep mode.
- state_out, out, 3: current state encoding, for debug display.

## Operation
- States: IDLE=0, SETTLE=1, BURST=2, LISTEN=3, REPORT=4.
- IDLE -> SETTLE when enable_in=1. The starting angle is ANGLE_MIN in sweep mode and hold_angle_in in hold mode. beam_angle_out loads on that transition.
- SETTLE: datapath_rst_out=1 for exactly SETTLE_CYCLES cycles, then -> BURST.
- BURST: tx_enable_out=1 for exactly BURST_CYCLES cycles, then -> LISTEN. echo_valid_in is ignored (ringdown).
- LISTEN: rx_enable_out=1 for exactly LISTEN_CYCLES cycles, then -> REPORT.
  - The first echo_valid_in in LISTEN latches range_in and sets the hit flag.
  - Later echoes in the same ping are ignored.
  - An echo in the final LISTEN cycle counts.
- REPORT (1 cycle): result_valid_out=1 with the latched angle, range and hit. On a miss, result_range_out is all ones and result_hit_out=0.
- Next transition, evaluated in REPORT:
  - enable_in=0 -> IDLE; beam_angle_out holds.
  - Sweep mode -> SETTLE with angle += ANGLE_STEP. At ANGLE_MAX the angle wraps to ANGLE_MIN and sweep_done_out=1 in this REPORT cycle.
  - Hold mode -> SETTLE with angle = hold_angle_in; sweep_done_out stays 0.
- Mode change: sweep_mode_in and hold_angle_in are sampled only on IDLE exit and in REPORT. A switch from hold to sweep restarts at ANGLE_MIN.
- enable_in deasserted mid-ping does not abort; the current ping completes and reports.
- datapath_rst_out is also 1 in IDLE.
- Hit flag and latched range clear on SETTLE entry.
- Arithmetic: angle math is signed ANGLE_WIDTH. Counters are sized $clog2 of the largest of the three cycle parameters and count down to 0.

## Timing
- All outputs are registered.
- Reset values: state IDLE, beam_angle_out=0, datapath_rst_out=1, and every other output 0 (result_range_out=0).
- rst_in asserted mid-ping forces reset values asynchronously. There is no partial result.
- Ping period = SETTLE_CYCLES + BURST_CYCLES + LISTEN_CYCLES + 1 cycles.
- beam_angle_out is stable from SETTLE entry through REPORT.
- tx_enable_out and rx_enable_out are never high together and never high while datapath_rst_out is high.
- The echo-to-result latency depends on the remaining listen time. result_* hold their values until the next REPORT.
- result_valid_out and sweep_done_out are single-cycle pulses.

## Test plan
All scenarios use SETTLE=2, BURST=4, LISTEN=10, angles -30..30 step 10 (period 17).
- Reset, then enable=1 in sweep mode with no echoes -> 7 results with angles -30,-20,...,30, all range 0xFFFF and hit=0, spaced 17 cycles apart. sweep_done pulses with angle 30, and the next ping uses -30.
- Echo pulses with range 0x0123 on LISTEN cycle 3 and range 0x0456 on cycle 7 -> result range 0x0123, hit=1. A pulse during BURST -> ignored (miss).
- Echo in the last LISTEN cycle with range 0x0042 -> hit=1, range 0x0042.
- Hold mode with hold_angle_in=-20 -> every result has angle -20 and sweep_done is never asserted. Switching to sweep mid-ping -> the next ping uses angle -30.
- enable dropped during BURST -> the ping completes, REPORT is issued, state returns to IDLE with datapath_rst_out=1 and no further tx.
- rst_in asserted mid-LISTEN for 1 cycle -> outputs go to reset values immediately, with no result_valid pulse. After release with enable=1, the sequence restarts at -30.
- Throughout all scenarios, the assertion "tx_enable and rx_enable never high together, and neither high while datapath_rst_out is high" holds.
